// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
//
// Register-file scoreboard for an in-order issue stage. One busy bit is kept
// per architectural register and is set when an instruction that writes it is
// accepted. It is cleared when the write-back for that register completes.
// A new instruction is held while any register it reads, or the register it
// writes, is still pending.
//
// Ports
//   clk             single clock, rising edge
//   rst             asynchronous active-high reset
//   issue_valid     instruction presented for issue
//   issue_rs1/rs2   source register indices
//   issue_rs1_used  rs1 is actually read
//   issue_rs2_used  rs2 is actually read
//   issue_rd        destination register index
//   issue_we        instruction writes the register file
//   issue_ready     issue accepted this cycle (combinational)
//   wb_valid        register-file write completes this cycle
//   wb_rd           register being written back
//   flush           discard all pending writes, block issue this cycle
//   busy_vec        per-register pending-write bits (bit 0 always 0)
//   pending_cnt     number of set bits in busy_vec (registered)
//   stall_cnt       saturating count of stalled issue cycles
//   state           0 = RUN, 1 = STALL (outcome of the previous cycle)
// -----------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rs1,
  input  logic [4:0]             issue_rs2,
  input  logic                   issue_rs1_used,
  input  logic                   issue_rs2_used,
  input  logic [4:0]             issue_rd,
  input  logic                   issue_we,
  output logic                   issue_ready,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic                   flush,
  output logic [31:0]            busy_vec,
  output logic [5:0]             pending_cnt,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   state
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  logic [31:0]            busy_reg;
  logic [31:0]            busy_next;
  logic [5:0]             pending_cnt_reg;
  logic [5:0]             pending_cnt_next;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;
  state_t                 state_reg;

  logic                   hazard;
  logic                   set_en;
  logic                   stall_inc;
  logic [31:0]            set_dec;
  logic [31:0]            clr_dec;

  // The hazard check looks only at the registered busy bits. A write-back in
  // the same cycle does not bypass it: the register file is read
  // combinationally but written on the edge, so the reader must wait one cycle.
  assign hazard = issue_valid &&
                  ((issue_rs1_used && busy_reg[issue_rs1]) ||
                   (issue_rs2_used && busy_reg[issue_rs2]) ||
                   (issue_we       && busy_reg[issue_rd]));

  assign issue_ready = issue_valid && !hazard && !flush;
  assign stall_inc   = issue_valid && !issue_ready;

  // The set decode is applied after the clear. When the same register is
  // both written back and re-claimed in one cycle, it stays busy.
  assign set_en  = issue_ready && issue_we && (issue_rd != 5'd0);
  assign set_dec = 32'(set_en) << issue_rd;
  assign clr_dec = 32'(wb_valid) << wb_rd;

  always_comb begin
    busy_next = '0;
    if (!flush) begin
      busy_next = (busy_reg & ~clr_dec) | set_dec;
    end
    busy_next[0] = 1'b0;
  end

  // The population count is taken from the next-state vector. This keeps the
  // registered count aligned with busy_vec in the same cycle.
  always_comb begin
    pending_cnt_next = '0;
    for (int i = 0; i < 32; i++) begin
      pending_cnt_next = pending_cnt_next + 6'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg        <= '0;
      pending_cnt_reg <= '0;
      stall_cnt_reg   <= '0;
      state_reg       <= ST_RUN;
    end else begin
      busy_reg        <= busy_next;
      pending_cnt_reg <= pending_cnt_next;
      if (stall_inc && (stall_cnt_reg != {STALL_CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      // A flush cycle counts as a stall. It still returns the FSM to RUN,
      // because every pending write is gone afterwards.
      case (state_reg)
        ST_RUN: begin
          if (issue_valid && hazard && !flush) begin
            state_reg <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (!issue_valid || !hazard || flush) begin
            state_reg <= ST_RUN;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign busy_vec    = busy_reg;
  assign pending_cnt = pending_cnt_reg;
  assign stall_cnt   = stall_cnt_reg;
  assign state       = state_reg;

endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 The block SHALL have parameter STALL_CNT_W, default 16, giving the width of the stall-cycle counter.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port issue_valid  input  1  an instruction is presented for issue this cycle.
REQ-005 The block SHALL have port issue_rs1, issue_rs2  input  5 each  source register indices (inst[19:15], inst[24:20]).
REQ-006 The block SHALL have port issue_rs1_used, issue_rs2_used  input  1 each  the source is actually read.
REQ-007 The block SHALL have port issue_rd  input  5  destination index (inst[11:7]).
REQ-008 The block SHALL have port issue_we  input  1  the instruction will write the register file (rf_we).
REQ-009 The block SHALL have port issue_ready  output  1  issue is accepted this cycle.
REQ-010 The block SHALL have port wb_valid  input  1  a register-file write completes this cycle.
REQ-011 The block SHALL have port wb_rd  input  5  the register being written back.
REQ-012 The block SHALL have port flush  input  1  discard all pending writes.
REQ-013 The block SHALL have port busy_vec  output  32  per-register pending-write bits; bit 0 is always 0.
REQ-014 The block SHALL have port pending_cnt  output  6  number of set bits in busy_vec.
REQ-015 The block SHALL have port stall_cnt  output  STALL_CNT_W  saturating count of stalled issue cycles.
REQ-016 The block SHALL have port state  output  1  0 = RUN, 1 = STALL.

Function
REQ-017 A hazard SHALL exist when issue_valid=1 and any of the following holds: (rs1_used and busy[rs1]); (rs2_used and busy[rs2]); (issue_we and busy[rd]) (WAW).
REQ-018 issue_ready SHALL be combinational: issue_valid and no hazard and not flush.
REQ-019 Index 0 SHALL never be busy; an issue with rd=0 SHALL set no bit.
REQ-020 On an accepted issue with issue_we=1 and rd!=0, busy[rd] SHALL be 1 from the next cycle.
REQ-021 wb_valid=1 SHALL clear busy[wb_rd] at the next edge. A same-cycle writeback SHALL NOT bypass the hazard check, because the RF read is combinational and the write is edge-triggered; the issue stalls one cycle.
REQ-022 A writeback to a non-busy register SHALL be ignored without error.
REQ-023 If the same cycle both clears and sets the same rd, the set SHALL win.
REQ-024 flush=1 SHALL clear all busy bits at the next edge, SHALL block issue that cycle, and SHALL take priority over the set and clear in the same cycle.
REQ-025 pending_cnt SHALL be a registered population count, consistent with busy_vec in the same cycle.
REQ-026 The FSM SHALL operate as follows:
- RUN to STALL when issue_valid and a hazard exist.
- STALL to RUN when the hazard clears, issue_valid drops, or flush is asserted.
- state SHALL reflect the previous cycle's outcome.
REQ-027 stall_cnt SHALL increment once per cycle in which issue_valid=1 and issue_ready=0 (flush cycles included), and SHALL saturate at all-ones without wrapping.
REQ-028 Accept latency SHALL be 0 cycles. Minimum hazard-resolution latency SHALL be 1 cycle after wb_valid.

Reset
REQ-029 While rst=1, asynchronously: busy_vec=0, pending_cnt=0, stall_cnt=0, state=RUN.
REQ-030 issue_ready SHALL follow REQ-018 during and after reset. Reset mid-stall SHALL drop all pending writes, so a held issue is accepted on the first cycle after reset deassertion.

Verification
REQ-031 RAW: issue rd=5, we=1 -> busy_vec=0x20, pending_cnt=1. Next issue rs1=5 -> issue_ready=0, state=STALL. wb_valid with wb_rd=5 -> issue_ready=1 on the following cycle, stall_cnt=2.
REQ-032 x0: issue rd=0, we=1, then issue rs1=0 -> no stall, busy_vec=0.
REQ-033 WAW plus simultaneous events: busy[7]=1. Issue rd=7 with a same-cycle wb_rd=7 -> stall one cycle, then accept, then busy[7]=1.
REQ-034 Flush: busy on regs 3, 4, 9, with a pending stalled issue. Assert flush -> issue_ready=0 that cycle, busy_vec=0 next cycle, issue accepted, state=RUN.
REQ-035 Saturation: STALL_CNT_W=4, hold a hazard for 20 cycles -> stall_cnt stops at 15.
REQ-036 Reset: assert rst asynchronously mid-STALL -> all outputs reset immediately, without waiting for clk.
